// File: rtl/post_add_sub_arbiter.sv
// Two-requester front end for one shared POST_ADD_SUB datapath, chaining carry/borrow across the words of a transaction.
// Define ARB_RR_EN for round-robin arbitration in IDLE; otherwise requester 0 has fixed priority.
module post_add_sub_arbiter #(
    parameter int WIDTH    = 48,
    parameter int CIN_REG  = 1,
    parameter int COUT_REG = 1
) (
    input  logic               CLK,
    input  logic               rst_a,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_x,
    input  logic [2*WIDTH-1:0] req_z,
    input  logic [1:0]         req_sub,
    input  logic [1:0]         req_cin,
    input  logic [1:0]         req_last,
    output logic [WIDTH-1:0]   dp_x,
    output logic [WIDTH-1:0]   dp_z,
    output logic               dp_opmode7,
    output logic               dp_cin,
    output logic               dp_ce,
    input  logic [WIDTH-1:0]   dp_p,
    input  logic               dp_cout,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_p,
    output logic               rsp_cout,
    output logic               rsp_last
);

    localparam logic [1:0] WAIT_CYC = 2'(CIN_REG + COUT_REG);

    typedef enum logic [1:0] {IDLE, BUSY, CHAIN} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             chain_q, chain_d;
    logic [1:0]       wait_q, wait_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             op_q, op_d;
    logic             cin_q, cin_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_p_q, rsp_p_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_last_q, rsp_last_d;
`ifdef ARB_RR_EN
    logic             rr_q, rr_d;
`endif

    logic       win;
    logic       sel;
    logic [1:0] grant;
    logic       fire;

    // Winner among valid requesters while IDLE; a lone requester always wins.
    always_comb begin
`ifdef ARB_RR_EN
        win = (req_valid == 2'b11) ? rr_q : req_valid[1];
`else
        win = ~req_valid[0];
`endif
    end

    always_comb begin
        grant = 2'b00;
        sel   = owner_q;
        case (state_q)
            IDLE: begin
                sel = win;
                if (|req_valid) begin
                    grant = win ? 2'b10 : 2'b01;
                end
            end
            CHAIN:   grant = owner_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = rst_a ? 2'b00 : grant;
    assign fire      = |(req_valid & req_ready);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        chain_d     = chain_q;
        wait_d      = wait_q;
        x_d         = x_q;
        z_d         = z_q;
        op_d        = op_q;
        cin_d       = cin_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_last_d  = rsp_last_q;
`ifdef ARB_RR_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            IDLE, CHAIN: begin
                if (fire) begin
                    state_d = BUSY;
                    owner_d = sel;
                    x_d     = sel ? req_x[2*WIDTH-1:WIDTH] : req_x[WIDTH-1:0];
                    z_d     = sel ? req_z[2*WIDTH-1:WIDTH] : req_z[WIDTH-1:0];
                    op_d    = req_sub[sel];
                    last_d  = req_last[sel];
                    // Only the first word of a transaction takes the requester's carry.
                    cin_d   = (state_q == IDLE) ? req_cin[sel] : chain_q;
                    wait_d  = WAIT_CYC;
                end
            end
            BUSY: begin
                if (wait_q == 2'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = owner_q;
                    rsp_p_d     = dp_p;
                    rsp_cout_d  = dp_cout;
                    rsp_last_d  = last_q;
                    chain_d     = dp_cout;
                    state_d     = last_q ? IDLE : CHAIN;
`ifdef ARB_RR_EN
                    if (last_q) begin
                        rr_d = ~owner_q;
                    end
`endif
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst_a) begin
        if (rst_a) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            chain_q     <= 1'b0;
            wait_q      <= 2'd0;
            x_q         <= '0;
            z_q         <= '0;
            op_q        <= 1'b0;
            cin_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_p_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_last_q  <= 1'b0;
`ifdef ARB_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            chain_q     <= chain_d;
            wait_q      <= wait_d;
            x_q         <= x_d;
            z_q         <= z_d;
            op_q        <= op_d;
            cin_q       <= cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_last_q  <= rsp_last_d;
`ifdef ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    // The datapath's carry registers only advance while a word is in flight.
    assign dp_ce      = (state_q == BUSY);
    assign dp_x       = x_q;
    assign dp_z       = z_q;
    assign dp_opmode7 = op_q;
    assign dp_cin     = cin_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_p      = rsp_p_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_last   = rsp_last_q;

endmodule

// File: tb/tb_post_add_sub_arbiter.sv
// Bench for post_add_sub_arbiter: directed cases plus randomized two-requester traffic against a word-level reference model.
`timescale 1ns/1ps
module tb_post_add_sub_arbiter;

    localparam int W   = 48;
    localparam int CR  = 1;
    localparam int COR = 1;
    localparam int LAT = CR + COR;

    logic           CLK = 1'b0;
    logic           rst_a = 1'b1;
    logic [1:0]     req_valid, req_ready, req_sub, req_cin, req_last;
    logic [2*W-1:0] req_x, req_z;
    logic [W-1:0]   dp_x, dp_z, dp_p, rsp_p;
    logic           dp_opmode7, dp_cin, dp_ce, dp_cout;
    logic           rsp_valid, rsp_id, rsp_cout, rsp_last;

    logic           vld[2];
    logic [W-1:0]   xs[2];
    logic [W-1:0]   zs[2];
    logic           subs[2], cins[2], lasts[2];

    assign req_valid = {vld[1], vld[0]};
    assign req_x     = {xs[1], xs[0]};
    assign req_z     = {zs[1], zs[0]};
    assign req_sub   = {subs[1], subs[0]};
    assign req_cin   = {cins[1], cins[0]};
    assign req_last  = {lasts[1], lasts[0]};

    post_add_sub_arbiter #(.WIDTH(W), .CIN_REG(CR), .COUT_REG(COR)) dut (
        .CLK(CLK), .rst_a(rst_a),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_z(req_z), .req_sub(req_sub), .req_cin(req_cin), .req_last(req_last),
        .dp_x(dp_x), .dp_z(dp_z), .dp_opmode7(dp_opmode7), .dp_cin(dp_cin), .dp_ce(dp_ce),
        .dp_p(dp_p), .dp_cout(dp_cout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_cout(rsp_cout), .rsp_last(rsp_last)
    );

    always #5 CLK = ~CLK;

    // Datapath stand-in: registered carry-in and registered result, both gated by C_ENABLE.
    logic         cin_r = 1'b0;
    logic [W:0]   out_r = '0;
    logic [W:0]   dp_f;
    logic         cin_eff;
    assign cin_eff = (CR != 0) ? cin_r : dp_cin;
    always_comb begin
        if (dp_opmode7) dp_f = {1'b0, dp_z} - {1'b0, dp_x} - {{W{1'b0}}, cin_eff};
        else            dp_f = {1'b0, dp_x} + {1'b0, dp_z} + {{W{1'b0}}, cin_eff};
    end
    always @(posedge CLK) begin
        if (dp_ce) begin
            cin_r <= dp_cin;
            out_r <= dp_f;
        end
    end
    assign {dp_cout, dp_p} = (COR != 0) ? out_r : dp_f;

    typedef struct {
        logic [W-1:0] p;
        logic         c;
        logic         last;
        logic         cin;
        logic [W-1:0] x;
        logic         id;
    } exp_t;

    exp_t  expq[$];
    logic  grant_log[$];
    logic  carry_run[2];
    logic  first_w[2];
    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;
    logic  inflight = 1'b0;
    int    hs_cyc = 0;
    logic  hs_id = 1'b0;
    int    lock_own = -1;
`ifdef ARB_RR_EN
    logic  rr_exp = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Word-level arithmetic: add gives carry above bit W-1, sub gives borrow when z < x+cin.
    function automatic void ref_word(input logic sub, input logic [W-1:0] x, input logic [W-1:0] z,
                                     input logic cin, output logic [W-1:0] p, output logic c);
        longint unsigned xv, zv, s;
        xv = 64'(x);
        zv = 64'(z);
        if (!sub) begin
            s = xv + zv + 64'(cin);
            p = s[W-1:0];
            c = s[W];
        end else begin
            s = zv - xv - 64'(cin);
            p = s[W-1:0];
            c = (zv < xv + 64'(cin));
        end
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return r[W-1:0];
        endcase
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        logic [1:0] er, hsv;
        exp_t       e;
        if (rst_a) begin
            inflight = 1'b0;
            lock_own = -1;
            expq.delete();
`ifdef ARB_RR_EN
            rr_exp = 1'b0;
`endif
        end else begin
            check_eq("rsp_valid", rsp_valid, inflight && (cyc - hs_cyc == LAT + 2));
            if (rsp_valid && inflight) begin
                check_eq("rsp_exp_avail", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check_eq("rsp_id", rsp_id, e.id);
                    check_eq("rsp_p", rsp_p, e.p);
                    check_eq("rsp_cout", rsp_cout, e.c);
                    check_eq("rsp_last", rsp_last, e.last);
                end
                inflight = 1'b0;
                if (rsp_last) begin
                    lock_own = -1;
`ifdef ARB_RR_EN
                    rr_exp = ~rsp_id;
`endif
                end else begin
                    lock_own = int'(rsp_id);
                end
            end
            if (inflight)                er = 2'b00;
            else if (lock_own >= 0)      er = (lock_own == 1) ? 2'b10 : 2'b01;
`ifdef ARB_RR_EN
            else if (req_valid == 2'b11) er = rr_exp ? 2'b10 : 2'b01;
`else
            else if (req_valid == 2'b11) er = 2'b01;
`endif
            else                         er = req_valid;
            check_eq("req_ready", req_ready, er);
            hsv = req_valid & req_ready;
            if (hsv != 2'b00) begin
                inflight = 1'b1;
                hs_cyc   = cyc;
                hs_id    = hsv[1];
                grant_log.push_back(hsv[1]);
            end
            check_eq("dp_ce", dp_ce, inflight && (cyc - hs_cyc >= 1) && (cyc - hs_cyc <= LAT + 1));
            if (inflight && cyc == hs_cyc + 1 && expq.size() != 0) begin
                e = expq[expq.size() - 1];
                check_eq("dp_cin", dp_cin, e.cin);
                check_eq("dp_x", dp_x, e.x);
            end
        end
    end

    task automatic send_word(input int id, input logic [W-1:0] x, input logic [W-1:0] z,
                             input logic sub, input logic cin, input logic last);
        int           b;
        logic         cu, c;
        logic [W-1:0] p;
        exp_t         e;
        xs[id] = x; zs[id] = z; subs[id] = sub; cins[id] = cin; lasts[id] = last;
        vld[id] = 1'b1;
        b = 0;
        do begin
            @(negedge CLK);
            b++;
        end while (req_ready[id] !== 1'b1 && b < 1000);
        if (req_ready[id] !== 1'b1) begin
            check_eq("hs_timeout", req_ready[id], 1);
            vld[id] = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        vld[id] = 1'b0;
        cu = first_w[id] ? cin : carry_run[id];
        ref_word(sub, x, z, cu, p, c);
        e.p = p; e.c = c; e.last = last; e.cin = cu; e.x = x; e.id = id[0];
        expq.push_back(e);
        carry_run[id] = c;
        first_w[id]   = last;
    endtask

    task automatic expect_rsp(input string tag, input logic id, input logic [W-1:0] p, input logic c);
        int b;
        b = 0;
        do begin
            @(negedge CLK);
            b++;
        end while (rsp_valid !== 1'b1 && b < 30);
        check_eq({tag, "_valid"}, rsp_valid, 1);
        check_eq({tag, "_id"}, rsp_id, id);
        check_eq({tag, "_p"}, rsp_p, p);
        check_eq({tag, "_cout"}, rsp_cout, c);
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        first_w[0] = 1'b1; first_w[1] = 1'b1;
        carry_run[0] = 1'b0; carry_run[1] = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((inflight || expq.size() != 0) && b < 200) begin
            @(posedge CLK);
            b++;
        end
        check_eq("drain", expq.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        vld[0] = 1'b0; vld[1] = 1'b0;
        rst_a = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        clear_model();
        rst_a = 1'b0;
    endtask

    task automatic rand_requester(input int id);
        int nw;
        for (int t = 0; t < 12; t++) begin
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                send_word(id, rand_word(), rand_word(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), (w == nw - 1));
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; xs[i] = '0; zs[i] = '0; subs[i] = 1'b0; cins[i] = 1'b0; lasts[i] = 1'b0;
        end
        clear_model();
        vld[0] = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_ce", dp_ce, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_dp_x", dp_x, 0);
        vld[0] = 1'b0;
        rst_a = 1'b0;
        @(posedge CLK);
        #1;

        send_word(0, 48'd5, 48'd7, 1'b0, 1'b1, 1'b1);
        expect_rsp("add1", 1'b0, 48'd13, 1'b0);

        send_word(1, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0);
        expect_rsp("chain0", 1'b1, 48'd0, 1'b1);
        send_word(1, 48'd0, 48'd0, 1'b0, 1'b0, 1'b1);
        check_eq("chain_dp_cin", dp_cin, 1);
        expect_rsp("chain1", 1'b1, 48'd1, 1'b0);

        send_word(0, 48'd3, 48'd2, 1'b1, 1'b0, 1'b1);
        expect_rsp("sub", 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1);

        base = grant_log.size();
        fork
            begin
                send_word(0, 48'd10, 48'd20, 1'b0, 1'b0, 1'b0);
                repeat (6) @(posedge CLK);
                #1;
                send_word(0, 48'd1, 48'd2, 1'b0, 1'b0, 1'b1);
            end
            begin
                @(posedge CLK);
                #1;
                send_word(1, 48'd4, 48'd4, 1'b0, 1'b0, 1'b1);
            end
        join
        drain();
        check_eq("lock_n", grant_log.size() - base, 3);
        if (grant_log.size() >= base + 3) begin
            check_eq("lock_g0", grant_log[base], 0);
            check_eq("lock_g1", grant_log[base + 1], 0);
            check_eq("lock_g2", grant_log[base + 2], 1);
        end

        send_word(0, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0);
        expect_rsp("rst_w0", 1'b0, 48'd0, 1'b1);
        send_word(0, 48'd1, 48'd1, 1'b0, 1'b0, 1'b1);
        @(posedge CLK);
        #1;
        rst_a = 1'b1;
        #1;
        check_eq("arst_ce", dp_ce, 0);
        check_eq("arst_dp_x", dp_x, 0);
        check_eq("arst_dp_cin", dp_cin, 0);
        check_eq("arst_rsp_cout", rsp_cout, 0);
        check_eq("arst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge CLK);
        #1;
        clear_model();
        rst_a = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        send_word(1, 48'd1, 48'd1, 1'b0, 1'b0, 1'b1);
        expect_rsp("post_rst", 1'b1, 48'd2, 1'b0);

        do_reset();
        base = grant_log.size();
        fork
            for (int k = 0; k < 4; k++) send_word(0, rand_word(), rand_word(), 1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 4; k++) send_word(1, rand_word(), rand_word(), 1'b1, 1'b1, 1'b1);
        join
        drain();
        check_eq("cont_n", grant_log.size() - base, 8);
        if (grant_log.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
                check_eq("cont_grant", grant_log[base + k], 1'(k % 2));
`else
                check_eq("cont_grant", grant_log[base + k], 0);
`endif
            end
        end

        fork
            rand_requester(0);
            rand_requester(1);
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
